// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: decodes IR_M, checks alignment, runs a req/ack bus
// access with byte enables and timeout, and returns aligned/extended load data.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] ALUOUT_M,
  input  logic [31:0] RT_M,
  input  logic [6:2]  EXC_M_in,
  input  logic        int_clr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        mem_stall,
  output logic [31:0] RD_M,
  output logic        ld_valid,
  output logic [6:2]  EXC_M_out
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Request captured at issue so the bus stays stable while the pipe is held.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ld;
    logic [1:0]  sz;   // 0 byte, 1 half, 2 word
    logic        sgn;
    logic [1:0]  off;
  } req_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          to_q;
  logic [31:0]   rd_q;
  req_t          req_q, req_d;
  logic          is_ld, is_st, sgn, misalign, issue;
  logic [1:0]    sz, a;
  logic          unused_ir;

  assign unused_ir = ^IR_M[25:0];
  assign a = ALUOUT_M[1:0];

  always_comb begin
    is_ld = 1'b0; is_st = 1'b0; sz = 2'd0; sgn = 1'b0;
    case (IR_M[31:26])
      6'b100000: begin is_ld = 1'b1; sz = 2'd0; sgn = 1'b1; end
      6'b100001: begin is_ld = 1'b1; sz = 2'd1; sgn = 1'b1; end
      6'b100011: begin is_ld = 1'b1; sz = 2'd2; end
      6'b100100: begin is_ld = 1'b1; sz = 2'd0; end
      6'b100101: begin is_ld = 1'b1; sz = 2'd1; end
      6'b101000: begin is_st = 1'b1; sz = 2'd0; end
      6'b101001: begin is_st = 1'b1; sz = 2'd1; end
      6'b101011: begin is_st = 1'b1; sz = 2'd2; end
      default: ;
    endcase
  end

  assign misalign = (is_ld | is_st) & (((sz == 2'd2) & (a != 2'd0)) | ((sz == 2'd1) & a[0]));
  assign issue = (state == IDLE) & (is_ld | is_st) & ~misalign & (EXC_M_in == 5'd0) & ~int_clr;

  always_comb begin
    req_d       = '0;
    req_d.we    = is_st;
    req_d.addr  = {ALUOUT_M[31:2], 2'b00};
    req_d.ld    = is_ld;
    req_d.sz    = sz;
    req_d.sgn   = sgn;
    req_d.off   = a;
    case (sz)
      2'd0:    begin req_d.be = 4'b0001 << a; req_d.wdata = {4{RT_M[7:0]}};  end
      2'd1:    begin req_d.be = 4'b0011 << a; req_d.wdata = {2{RT_M[15:0]}}; end
      default: begin req_d.be = 4'b1111;      req_d.wdata = RT_M;            end
    endcase
  end

  function automatic logic [31:0] ld_align(input logic [31:0] d, input logic [1:0] s,
                                           input logic sx, input logic [1:0] off);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (s)
      2'd0:    ld_align = {{24{sx & sh[7]}}, sh[7:0]};
      2'd1:    ld_align = {{16{sx & sh[15]}}, sh[15:0]};
      default: ld_align = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue) state_nx = BUSY;
      BUSY:    if (bus_ack || cnt == LAST) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; to_q <= 1'b0; rd_q <= '0; req_q <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin cnt <= '0; to_q <= 1'b0; req_q <= req_d; end
        BUSY: begin
          cnt <= cnt + 1'b1;
          // ack on the last counted cycle still wins over the timeout
          if (bus_ack) begin
            if (req_q.ld) rd_q <= ld_align(bus_rdata, req_q.sz, req_q.sgn, req_q.off);
          end else if (cnt == LAST) begin
            to_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_req = 1'b0; bus_we = 1'b0; bus_be = 4'b0000; mem_stall = 1'b0; ld_valid = 1'b0;
    case (state)
      IDLE:    mem_stall = issue;
      BUSY:    begin bus_req = 1'b1; bus_we = req_q.we; bus_be = req_q.be; mem_stall = 1'b1; end
      DONE:    ld_valid = req_q.ld & ~to_q;
      default: ;
    endcase
  end

  always_comb begin
    if (EXC_M_in != 5'd0)            EXC_M_out = EXC_M_in;
    else if (misalign)               EXC_M_out = is_ld ? 5'd4 : 5'd5;
    else if (state == DONE && to_q)  EXC_M_out = 5'd7;
    else                             EXC_M_out = 5'd0;
  end

  assign bus_addr  = req_q.addr;
  assign bus_wdata = req_q.wdata;
  assign RD_M      = rd_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit with a behavioural access model.
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, LUI = 6'h0F;

  logic        clk = 0, reset = 0;
  logic [31:0] IR_M = 0, ALUOUT_M = 0, RT_M = 0, bus_rdata = 0;
  logic [6:2]  EXC_M_in = 0;
  logic        int_clr = 0, bus_ack = 0;
  logic        bus_req, bus_we, mem_stall, ld_valid;
  logic [31:0] bus_addr, bus_wdata, RD_M;
  logic [3:0]  bus_be;
  logic [6:2]  EXC_M_out;

  int checks = 0, errors = 0;
  logic [31:0] rd_model = 0;

  // observations of one access
  int o_req, o_stall;
  bit o_done, o_noacc, o_stable, o_ldv, o_ldv_early, o_stall_first;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_rd;
  logic [6:2]  o_exc_first, o_exc_done;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .IR_M(IR_M), .ALUOUT_M(ALUOUT_M), .RT_M(RT_M),
    .EXC_M_in(EXC_M_in), .int_clr(int_clr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .mem_stall(mem_stall), .RD_M(RD_M), .ld_valid(ld_valid),
    .EXC_M_out(EXC_M_out)
  );

  always #5 clk = ~clk;

  function automatic int size_of(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit is_load(input logic [5:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic bit is_mem(input logic [5:0] op);
    return is_load(op) || op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [3:0] model_be(input logic [5:0] op, input int a);
    int n = size_of(op);
    return 4'(((1 << n) - 1) * (1 << a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] rt);
    case (size_of(op))
      1: return 32'(rt[7:0]) * 32'h0101_0101;
      2: return 32'(rt[15:0]) * 32'h0001_0001;
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] d, input int a);
    longint v, m;
    if (op == LW) return d;
    m = (size_of(op) == 1) ? 256 : 65536;
    v = (longint'(d) / (longint'(1) << (8 * a))) % m;
    if ((op == LB || op == LH) && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      IR_M = 0; int_clr = 0; bus_ack = 0; EXC_M_in = 0;
    end
  endtask

  // Drive one instruction until its access finishes; bus acks on BUSY cycle ack_at (0 = never).
  task automatic do_access(input logic [31:0] ir, addr, rt, input logic [6:2] exc, input int ack_at,
                           input logic [31:0] rdata, input bit clr_first, input bit clr_busy);
    int reqs = 0;
    o_stall = 0; o_done = 0; o_noacc = 0; o_stable = 1; o_ldv = 0; o_ldv_early = 0;
    for (int cyc = 0; cyc < 40 && !o_done; cyc++) begin
      @(negedge clk);
      IR_M = ir; ALUOUT_M = addr; RT_M = rt; EXC_M_in = exc;
      int_clr = (cyc == 0) ? clr_first : clr_busy;
      bus_ack = bus_req && (reqs + 1 == ack_at);
      bus_rdata = bus_ack ? rdata : $urandom;
      #1;
      if (cyc == 0) begin o_exc_first = EXC_M_out; o_stall_first = mem_stall; end
      if (mem_stall) o_stall++;
      if (bus_req) begin
        if (reqs == 0) begin
          o_we = bus_we; o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata;
        end else if (o_we !== bus_we || o_be !== bus_be || o_addr !== bus_addr || o_wdata !== bus_wdata)
          o_stable = 0;
        reqs++;
        if (ld_valid) o_ldv_early = 1;
      end else if (reqs > 0) begin
        o_rd = RD_M; o_ldv = ld_valid; o_exc_done = EXC_M_out; o_done = 1;
      end else if (cyc == 0 && !mem_stall) begin
        o_noacc = 1; o_done = 1;
        if (ld_valid) o_ldv_early = 1;
      end
    end
    bus_ack = 0; int_clr = 0;
    o_req = reqs;
    if (!o_done) begin errors++; $display("FAIL access_bound: access did not finish within 40 cycles"); end
    checks++;
  endtask

  task automatic test_reset;
    reset = 1; idle(2); reset = 0; #1;
    checks++; if (bus_req !== 0 || mem_stall !== 0 || ld_valid !== 0) begin errors++;
      $display("FAIL reset_ctrl: req=%0b stall=%0b ldv=%0b expected 0", bus_req, mem_stall, ld_valid); end
    checks++; if (RD_M !== 0 || EXC_M_out !== 0 || bus_be !== 0 || bus_we !== 0) begin errors++;
      $display("FAIL reset_data: rd=%h exc=%0d be=%b we=%b expected 0", RD_M, EXC_M_out, bus_be, bus_we); end
    checks++; if (bus_addr !== 0 || bus_wdata !== 0) begin errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h expected 0", bus_addr, bus_wdata); end
  endtask

  task automatic test_lw;
    do_access({LW, 26'h0}, 32'h10, 0, 0, 2, 32'hDEADBEEF, 0, 0);
    rd_model = 32'hDEADBEEF;
    checks++; if (o_req !== 2 || o_stall !== 3) begin errors++;
      $display("FAIL lw_timing: req=%0d stall=%0d expected 2/3", o_req, o_stall); end
    checks++; if (o_be !== 4'hF || o_we !== 0 || o_addr !== 32'h10) begin errors++;
      $display("FAIL lw_bus: be=%b we=%b addr=%h expected 1111/0/10", o_be, o_we, o_addr); end
    checks++; if (o_rd !== 32'hDEADBEEF || o_ldv !== 1 || o_exc_done !== 0) begin errors++;
      $display("FAIL lw_done: rd=%h ldv=%b exc=%0d expected deadbeef/1/0", o_rd, o_ldv, o_exc_done); end
    idle(1);
  endtask

  task automatic test_sb;
    do_access({SB, 26'h0}, 32'h13, 32'hA5, 0, 1, 32'h0, 0, 0);
    checks++; if (o_be !== 4'b1000 || o_wdata !== 32'hA5A5A5A5 || o_we !== 1 || o_addr !== 32'h10) begin errors++;
      $display("FAIL sb_bus: be=%b wdata=%h we=%b addr=%h expected 1000/a5a5a5a5/1/10", o_be, o_wdata, o_we, o_addr); end
    checks++; if (o_ldv !== 0 || o_ldv_early !== 0 || o_rd !== rd_model) begin errors++;
      $display("FAIL sb_ldv: ldv=%b rd=%h expected 0/%h", o_ldv, o_rd, rd_model); end
    idle(1);
  endtask

  task automatic test_load_ext;
    logic [5:0] ops [4] = '{LB, LBU, LH, LHU};
    logic [31:0] dat [4] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 4; i++) begin
      do_access({ops[i], 26'h0}, 32'h102, 0, 0, 1, dat[i], 0, 0);
      rd_model = exp[i];
      checks++; if (o_rd !== exp[i] || o_ldv !== 1) begin errors++;
        $display("FAIL load_ext%0d: rd=%h ldv=%b expected %h/1", i, o_rd, o_ldv, exp[i]); end
    end
    idle(1);
  endtask

  task automatic test_misalign;
    do_access({LW, 26'h0}, 32'h1002, 0, 0, 1, 0, 0, 0);
    checks++; if (o_noacc !== 1 || o_exc_first !== 4 || o_req !== 0 || o_stall !== 0) begin errors++;
      $display("FAIL lw_misalign: exc=%0d req=%0d stall=%0d expected 4/0/0", o_exc_first, o_req, o_stall); end
    do_access({SH, 26'h0}, 32'h1001, 0, 0, 1, 0, 0, 0);
    checks++; if (o_noacc !== 1 || o_exc_first !== 5) begin errors++;
      $display("FAIL sh_misalign: exc=%0d noacc=%b expected 5/1", o_exc_first, o_noacc); end
    do_access({SW, 26'h0}, 32'h1000, 0, 5'd10, 1, 0, 0, 0);
    checks++; if (o_noacc !== 1 || o_exc_first !== 10 || o_req !== 0) begin errors++;
      $display("FAIL exc_pass: exc=%0d req=%0d expected 10/0", o_exc_first, o_req); end
    idle(1);
  endtask

  task automatic test_timeout;
    do_access({SW, 26'h0}, 32'h40, 32'h1234, 0, 0, 0, 0, 0);
    checks++; if (o_req !== TIMEOUT || o_stall !== TIMEOUT + 1 || o_stable !== 1) begin errors++;
      $display("FAIL timeout_len: req=%0d stall=%0d stable=%b expected %0d/%0d/1", o_req, o_stall, o_stable, TIMEOUT, TIMEOUT + 1); end
    checks++; if (o_exc_done !== 7 || o_ldv !== 0) begin errors++;
      $display("FAIL timeout_exc: exc=%0d ldv=%b expected 7/0", o_exc_done, o_ldv); end
    idle(1);
    do_access({LW, 26'h0}, 32'h44, 0, 0, 0, 0, 0, 0);
    checks++; if (o_ldv !== 0 || o_rd !== rd_model || o_exc_done !== 7) begin errors++;
      $display("FAIL timeout_ld: ldv=%b rd=%h exc=%0d expected 0/%h/7", o_ldv, o_rd, o_exc_done, rd_model); end
    idle(1);
  endtask

  task automatic test_reset_busy;
    int n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      @(negedge clk); IR_M = {LW, 26'h0}; ALUOUT_M = 32'h80; #1;
      if (bus_req) n++;
      if (n == 3) begin reset = 1; IR_M = 0; end
    end
    @(negedge clk); reset = 0; #1;
    rd_model = 0;
    checks++; if (n !== 3 || bus_req !== 0 || mem_stall !== 0 || ld_valid !== 0 || RD_M !== 0) begin errors++;
      $display("FAIL reset_busy: n=%0d req=%b stall=%b ldv=%b rd=%h expected 3/0/0/0/0", n, bus_req, mem_stall, ld_valid, RD_M); end
    @(negedge clk); #1;
    checks++; if (bus_req !== 0 || ld_valid !== 0) begin errors++;
      $display("FAIL reset_busy_idle: req=%b ldv=%b expected 0/0", bus_req, ld_valid); end
  endtask

  task automatic test_int_clr;
    @(negedge clk); IR_M = {LW, 26'h0}; ALUOUT_M = 32'h20; int_clr = 1; #1;
    checks++; if (mem_stall !== 0) begin errors++; $display("FAIL clr_stall: stall=%b expected 0", mem_stall); end
    @(negedge clk); IR_M = 0; int_clr = 0; bus_ack = 1; bus_rdata = 32'h5555AAAA; #1;
    checks++; if (bus_req !== 0 || ld_valid !== 0) begin errors++;
      $display("FAIL clr_issue: req=%b ldv=%b expected 0/0", bus_req, ld_valid); end
    @(negedge clk); bus_ack = 0; #1;
    checks++; if (ld_valid !== 0 || RD_M !== rd_model) begin errors++;
      $display("FAIL stray_ack: ldv=%b rd=%h expected 0/%h", ld_valid, RD_M, rd_model); end
    do_access({LW, 26'h0}, 32'h24, 0, 0, 3, 32'h12345678, 0, 1);
    rd_model = 32'h12345678;
    checks++; if (o_req !== 3 || o_ldv !== 1 || o_rd !== 32'h12345678) begin errors++;
      $display("FAIL clr_busy: req=%0d ldv=%b rd=%h expected 3/1/12345678", o_req, o_ldv, o_rd); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    do_access({LW, 26'h0}, 32'h30, 0, 0, 1, 32'hCAFEF00D, 0, 0);
    checks++; if (o_req !== 1 || o_stall !== 2 || o_rd !== 32'hCAFEF00D) begin errors++;
      $display("FAIL b2b_first: req=%0d stall=%0d rd=%h expected 1/2/cafef00d", o_req, o_stall, o_rd); end
    do_access({LHU, 26'h0}, 32'h32, 0, 0, 1, 32'hBEEF0000, 0, 0);
    rd_model = 32'h0000BEEF;
    checks++; if (o_stall_first !== 1 || o_req !== 1 || o_rd !== 32'h0000BEEF || o_ldv !== 1) begin errors++;
      $display("FAIL b2b_second: stall0=%b req=%0d rd=%h ldv=%b expected 1/1/0000beef/1", o_stall_first, o_req, o_rd, o_ldv); end
    idle(1);
  endtask

  task automatic test_random;
    logic [5:0] ops [9] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, LUI};
    for (int i = 0; i < 30; i++) begin
      logic [5:0] op; logic [31:0] addr, rt, rd, exp_wd; logic [6:2] exc, exp_exc;
      int ack, a, exp_req; bit aligned, acc, to;
      op = ops[$urandom_range(0, 8)]; addr = $urandom; rt = $urandom; rd = $urandom;
      exc = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      ack = $urandom_range(1, TIMEOUT + 3); if (ack > TIMEOUT) ack = 0;
      do_access({op, 26'($urandom)}, addr, rt, exc, ack, rd, 0, 1'($urandom_range(0, 1)));
      a = int'(addr[1:0]);
      aligned = (a % size_of(op)) == 0;
      acc = is_mem(op) && exc == 0 && aligned;
      exp_exc = (exc != 0) ? exc : (is_mem(op) && !aligned) ? (is_load(op) ? 5'd4 : 5'd5) : 5'd0;
      if (!acc) begin
        checks++; if (o_noacc !== 1 || o_req !== 0 || o_exc_first !== exp_exc || o_ldv_early !== 0) begin errors++;
          $display("FAIL rnd%0d_noacc: noacc=%b req=%0d exc=%0d expected 1/0/%0d", i, o_noacc, o_req, o_exc_first, exp_exc); end
      end else begin
        to = (ack == 0);
        exp_req = to ? TIMEOUT : ack;
        exp_wd = model_wdata(op, rt);
        if (is_load(op) && !to) rd_model = model_load(op, rd, a);
        checks++; if (o_req !== exp_req || o_stall !== exp_req + 1 || o_stable !== 1) begin errors++;
          $display("FAIL rnd%0d_timing: req=%0d stall=%0d stable=%b expected %0d/%0d/1", i, o_req, o_stall, o_stable, exp_req, exp_req + 1); end
        checks++; if (o_be !== model_be(op, a) || o_we !== !is_load(op) || o_addr !== {addr[31:2], 2'b00}) begin errors++;
          $display("FAIL rnd%0d_bus: be=%b we=%b addr=%h expected %b/%b/%h", i, o_be, o_we, o_addr, model_be(op, a), !is_load(op), {addr[31:2], 2'b00}); end
        checks++; if (!is_load(op) && o_wdata !== exp_wd) begin errors++;
          $display("FAIL rnd%0d_wdata: wdata=%h expected %h", i, o_wdata, exp_wd); end
        checks++; if (o_rd !== rd_model || o_ldv !== (is_load(op) && !to) || o_exc_done !== (to ? 5'd7 : 5'd0) || o_ldv_early !== 0) begin errors++;
          $display("FAIL rnd%0d_done: rd=%h ldv=%b exc=%0d expected %h/%b/%0d", i, o_rd, o_ldv, o_exc_done, rd_model, is_load(op) && !to, to ? 7 : 0); end
      end
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_lw;
    test_sb;
    test_load_ext;
    test_misalign;
    test_timeout;
    test_reset_busy;
    test_int_clr;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access engine for the pipelined MIPS core. It consumes the EX/MEM pipeline register outputs and decodes load/store instructions from the instruction field. It then performs alignment checking, drives a req/ack data bus with byte enables, and stalls the pipeline until the access completes or times out. Load data is returned aligned and extended for the MEM/WB register. The exception code is forwarded and updated alongside it.

## Interface
- TIMEOUT, 16: maximum cycles in BUSY without bus_ack before the access is aborted (≥2).

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- IR_M  in  32  instruction in MEM stage
- ALUOUT_M  in  32  effective address
- RT_M  in  32  store source data
- EXC_M_in  in  5 [6:2]  exception code from earlier stages, 0 = none
- int_clr  in  1  interrupt flush request this cycle
- bus_req  out  1  access request, held until ack or abort
- bus_we  out  1  1 = write
- bus_addr  out  32  word address {ALUOUT_M[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion strobe
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- RD_M  out  32  aligned/extended load result
- ld_valid  out  1  RD_M valid this cycle
- EXC_M_out  out  5 [6:2]  exception code to MEM/WB

## Operation
- Decode from IR_M[31:26]:
  - lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101
  - sb 101000, sh 101001, sw 101011
  - anything else is "no access".
- Alignment: word needs addr[1:0]=0; half needs addr[0]=0; byte is always aligned.
- EXC_M_out priority:
  1. EXC_M_in≠0 passes through unchanged, with no access.
  2. Misaligned load → 4 (AdEL); misaligned store → 5 (AdES), with no access.
  3. Bus timeout → 7 (DBE).
  4. Otherwise 0.
- An access is issued only when: decoded load/store, no exception, and int_clr=0.
- Byte enables (little-endian; a = addr[1:0]):
  - word: be = 1111
  - half: be = 0011<<a
  - byte: be = 0001<<a
- Store data: wdata = RT_M (word), {2{RT_M[15:0]}} (half), {4{RT_M[7:0]}} (byte).
- Load data: take the byte or half at offset a from the captured rdata. Sign-extend for lb/lh, zero-extend for lbu/lhu; lw is taken unchanged.
- FSM states IDLE, BUSY, DONE; cycle counter cnt.
  - IDLE:
    - Issue condition true → BUSY next edge, cnt←0.
    - mem_stall is asserted combinationally in the same cycle.
  - BUSY:
    - bus_req=1; bus_we/addr/be/wdata held constant; mem_stall=1; cnt increments each cycle.
    - bus_ack=1 → capture bus_rdata, go to DONE.
    - cnt=TIMEOUT-1 with no ack → go to DONE with the timeout flag set; no data is captured.
  - DONE:
    - mem_stall=0.
    - ld_valid=1 for a load without timeout.
    - EXC_M_out=7 if timed out.
    - Next edge → IDLE.
- int_clr during BUSY is ignored: an issued transaction always completes or times out. int_clr in IDLE suppresses issue.
- Outside BUSY: bus_req=0, bus_we=0, be=0.
- In IDLE/DONE, RD_M holds its last value.

## Timing
- Reset values: state=IDLE, cnt=0, all outputs 0 (RD_M=0, EXC_M_out=0 when EXC_M_in=0).
- Reset mid-BUSY: bus_req deasserts after that edge; the access is abandoned; no ld_valid.
- Minimum access is 3 cycles: IDLE (stall) → BUSY (ack in its first cycle) → DONE.
- Latency = 2 + number of BUSY cycles.
- Maximum stall is TIMEOUT+1 cycles.
- bus_ack outside BUSY is ignored.
- Back-to-back memory instructions: after DONE returns to IDLE, the next IR_M is evaluated in that IDLE cycle. There is no dead cycle beyond DONE.
- EXC_M_out is combinational from EXC_M_in, alignment and the timeout flag.

## Test plan
- lw at 0x0000_0010, ack on 2nd BUSY cycle with rdata 0xDEADBEEF:
  - bus_req for 2 cycles, be=1111, we=0
  - mem_stall for 3 cycles
  - DONE: RD_M=0xDEADBEEF, ld_valid=1, EXC=0
- sb at 0x0000_0013, RT_M=0x0000_00A5:
  - be=1000, wdata=0xA5A5A5A5, we=1
  - ld_valid stays 0
- lb/lbu at offset 2 with rdata 0x0080_0000 → 0xFFFFFF80 / 0x00000080.
- lh/lhu at offset 2 with rdata 0x8001_0000 → 0xFFFF8001 / 0x00008001.
- Misalignment and exception pass-through:
  - lw at 0x…02 → EXC_M_out=4, no bus_req, no stall.
  - sh at 0x…01 → EXC_M_out=5.
  - EXC_M_in=10 on a sw → passes 10, no access.
- Timeout: sw with no ack → bus_req for exactly 16 cycles, then DONE with EXC_M_out=7.
- Reset and int_clr interaction:
  - reset asserted in 3rd BUSY cycle → bus_req=0 next cycle, state IDLE.
  - int_clr in the IDLE issue cycle → no request.
  - int_clr during BUSY → transaction still completes.
